port_out_uart_tx: RTL and testbench
===================================

// Module: port_out_uart_tx
// PURPOSE
//  Byte-wide UART transmitter that consumes the processor's output port.
//  Bytes the processor writes to PortOut are pushed into a small FIFO and serialised as 8N1 frames on tx, LSB first.
//  Sits directly downstream of the MIPS core's PortOut path.
// PARAMETERS
//  BAUD_DIV    434  clocks per serial bit; 50 MHz / 115200. Legal range 2..65535.
//  FIFO_AW     3    FIFO address width; depth = 2**FIFO_AW = 8 bytes.
// PORTS
//  clk        in   1          system clock; all logic on its rising edge
//  reset      in   1          asynchronous, active-low reset
//  wr_en      in   1          push request; one byte per cycle
//  wr_data    in   8          byte to send; PortOut[7:0] from the core
//  tx         out  1          serial line; idles high
//  full       out  1          FIFO holds 2**FIFO_AW bytes
//  busy       out  1          frame in progress OR FIFO not empty
//  count      out  FIFO_AW+1  bytes currently in the FIFO
//  overflow   out  1          sticky flag: a push was dropped
// BEHAVIOUR
//  Reset (reset=0, asynchronous): tx=1, full=0, busy=0, count=0, overflow=0, FSM=IDLE.
//   FIFO pointers, baud counter and bit counter are cleared.
//   Reset mid-frame aborts the frame at once; tx returns high asynchronously.
//  Push: accepted when wr_en=1 and (count<DEPTH or a pop occurs in the same cycle).
//   Otherwise the byte is dropped and overflow is set until the next reset.
//  Pop: happens only in IDLE when count!=0; shift_reg is loaded with the FIFO head.
//   Push and pop in the same cycle: count is unchanged; the pointers wrap mod DEPTH.
//  FSM states and transitions:
//   IDLE  -> START  when count!=0 (pop occurs).
//   START -> DATA   tx=0 for BAUD_DIV clocks.
//   DATA  -> STOP   tx=shift_reg[0] for BAUD_DIV clocks per bit; shift right; 8 bits; bit_cnt 0..7.
//   STOP  -> IDLE   tx=1 for BAUD_DIV clocks.
//  Baud counter: counts 0..BAUD_DIV-1 and restarts at 0 on every state or bit change.
//  Latency: a byte pushed at edge E0 into an empty FIFO in IDLE is popped at E1.
//   tx is registered and falls at E1.
//   The frame occupies 10*BAUD_DIV clocks. FSM is in IDLE again at E1+10*BAUD_DIV.
//  Back-to-back: from STOP->IDLE with FIFO non-empty, the next pop occurs on the following edge.
//   The resulting 1-clock extra stop time is legal.
//  full = (count==DEPTH). busy = (state!=IDLE) | (count!=0). Both are combinational from registers.
//  wr_data must be stable only in the cycle where wr_en=1.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP.
//   tx = ^byte (even parity) for BAUD_DIV clocks; the frame is 11*BAUD_DIV clocks (8E1).
//  UART_TX_PARITY_EN undefined: there is no PARITY state; the frame is 10*BAUD_DIV clocks (8N1).
// TESTING (BAUD_DIV=4, FIFO_AW=3 unless noted)
//  1 Reset: hold reset=0 with wr_en=1 -> tx=1, count=0, busy=0, overflow=0 throughout.
//  2 Single byte: push 0xA5 at E0 -> tx=0 E1..E4, then bits 1,0,1,0,0,1,0,1 at 4 clocks each.
//    Then tx=1 for 4 clocks; busy falls at E41.
//  3 Fill: push 10 bytes on consecutive cycles from idle -> 1st popped, 8 queued, 10th dropped.
//    Expect full=1, count=8, overflow=1; all 9 accepted bytes appear in order on tx.
//  4 Simultaneous push and pop at count=8 -> byte accepted, count stays 8, overflow stays 0.
//  5 Reset mid-frame: assert reset during DATA bit 3 -> tx=1 immediately, count=0.
//    Push 0x3C after release -> a clean full frame is sent.
//  6 With UART_TX_PARITY_EN: push 0x07 -> parity bit=1, frame 44 clocks; push 0x03 -> parity bit=0.

Source files
------------

// File: rtl/port_out_uart_tx.sv
// Byte-wide UART transmitter fed from the core's PortOut through a small FIFO; 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module port_out_uart_tx #(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_AW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             tx,
    output logic             full,
    output logic             busy,
    output logic [FIFO_AW:0] count,
    output logic             overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q;
    logic               tx_q;
    logic [BW-1:0]      baud_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               overflow_q;
    logic [7:0]         mem_q [DEPTH];
`ifdef UART_TX_PARITY_EN
    logic               parity_q;
`endif

    logic pop;
    logic push;
    logic baud_end;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pop      = (state_q == S_IDLE) && (count_q != '0);
        push     = wr_en && (!full || pop);
        baud_end = (baud_q == BW'(BAUD_DIV - 1));
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wr_en && !push) overflow_q <= 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; entries are only read after being written, and a reset-free array maps to RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q  <= S_START;
                        tx_q     <= 1'b0;
                        baud_q   <= '0;
                        shift_q  <= mem_q[rd_ptr_q];
                        rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^mem_q[rd_ptr_q];
`endif
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            // tx is registered, so it takes the bit that the shift exposes next
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_end) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        baud_q  <= '0;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_end) begin
                        state_q <= S_IDLE;
                        baud_q  <= '0;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign full     = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign busy     = (state_q != S_IDLE) || (count_q != '0);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_port_out_uart_tx.sv
// Randomised scoreboard bench for port_out_uart_tx: a frame-level reference model predicts FIFO
// occupancy and transmitted bytes; an independent monitor decodes tx and compares against the queue.
module tb_port_out_uart_tx;
    localparam int BAUD  = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * BAUD;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx;
    logic          full;
    logic          busy;
    logic [AW:0]   count;
    logic          overflow;

    port_out_uart_tx #(.BAUD_DIV(BAUD), .FIFO_AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx       (tx),
        .full     (full),
        .busy     (busy),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q [$];
    int         m_cnt = 0;
    int         m_rem = 0;
    bit         m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic even_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
        return logic'(ones % 2);
    endfunction

    // Reference: the transmitter is idle when no frame time remains; a pop starts a FRAME-clock frame.
    task automatic model_step(input logic we, input logic [7:0] d);
        bit pop;
        bit accept;
        pop = (m_rem == 0) && (m_cnt != 0);
        if (m_rem > 0) m_rem--;
        if (pop) m_rem = FRAME;
        accept = we && ((m_cnt < DEPTH) || pop);
        if (we && !accept) m_ovf = 1'b1;
        if (accept) exp_q.push_back(d);
        m_cnt = m_cnt + int'(accept) - int'(pop);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_rem = 0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic cycle(input logic we, input logic [7:0] d);
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        model_step(we, d);
        #1;
        check("count", count, m_cnt);
        check("full", full, m_cnt == DEPTH);
        check("busy", busy, (m_rem != 0) || (m_cnt != 0));
        check("overflow", overflow, m_ovf);
    endtask

    task automatic apply_reset(input int n);
        reset   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        model_reset();
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_tx", tx, 1);
            check("rst_count", count, 0);
            check("rst_busy", busy, 0);
            check("rst_overflow", overflow, 0);
        end
        reset = 1'b1;
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_rem != 0 || m_cnt != 0) && n < 5000) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check("drain_in_time", n < 5000, 1);
        repeat (4) cycle(1'b0, 8'h00);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    // Monitor: decodes each frame from tx, sampled on the falling clock edge.
    initial begin : monitor
        logic             prev;
        logic             aborted;
        logic             stable;
        logic [FRAME-1:0] smp;
        logic [NB-1:0]    bits;
        logic [7:0]       exp_b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && tx === 1'b0) begin
                smp     = '0;
                smp[0]  = tx;
                aborted = 1'b0;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[k] = tx;
                end
                if (!aborted) begin
                    stable = 1'b1;
                    for (int b = 0; b < NB; b++) begin
                        bits[b] = smp[b*BAUD];
                        for (int s = 1; s < BAUD; s++)
                            if (smp[b*BAUD+s] !== bits[b]) stable = 1'b0;
                    end
                    check("bit_timing", stable, 1);
                    check("start_bit", bits[0], 0);
                    check("stop_bit", bits[NB-1], 1);
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check("frame_data", bits[8:1], exp_b);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", bits[9], even_par(exp_b));
`endif
                    end
                end
                prev = aborted ? 1'b1 : tx;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : stimulus
        int n;
        apply_reset(5);

        // Single byte: frame timing and the busy fall edge
        cycle(1'b1, 8'hA5);
        n = 0;
        do begin
            cycle(1'b0, 8'h00);
            n++;
        end while (busy && n < 200);
        check("busy_fall_edge", n, FRAME + 1);
        drain();

        // Fill: ten consecutive pushes from idle, the tenth is dropped
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'h10 + 8'(i));
        check("fill_full", full, 1);
        check("fill_count", count, DEPTH);
        check("fill_overflow", overflow, 1);
        drain();

        // Push coinciding with a pop at count=DEPTH is accepted
        apply_reset(2);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'h60 + 8'(i));
        n = 0;
        while (m_rem != 0 && n < 200) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        cycle(1'b1, 8'h5A);
        check("simul_count", count, DEPTH);
        check("simul_overflow", overflow, 0);
        drain();

        // Reset during data bit 3 aborts the frame immediately
        cycle(1'b1, 8'hC3);
        repeat (18) cycle(1'b0, 8'h00);
        reset = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_count", count, 0);
        apply_reset(3);
        cycle(1'b1, 8'h3C);
        drain();

        // Randomised bursts and gaps, including overflow episodes
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                n = $urandom_range(1, 12);
                for (int j = 0; j < n; j++) cycle(1'b1, 8'($urandom));
            end else begin
                cycle(1'b0, 8'($urandom));
            end
        end
        drain();

        // Parity pattern bytes (odd and even weight)
        cycle(1'b1, 8'h07);
        cycle(1'b1, 8'h03);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
